// File: rtl/base_station_ho_if.sv
// base_station_ho_if: DM / server / peer-station signals of one handover controller.
interface base_station_ho_if #(
    parameter int NUM_BS = 3,
    parameter int SQ_W   = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = (NUM_BS > 1) ? $clog2(NUM_BS) : 1
) ();
    logic              start;
    logic [NUM_BS-1:0] ho_in;
    logic [NUM_BS-1:0] ack_in;
    logic [NUM_BS-1:0] ho_out;
    logic              ack_out;
    logic [SQ_W-1:0]   dm_sq;
    logic              dm_target_valid;
    logic [IDX_W-1:0]  dm_target;
    logic              dm_request;
    logic              dm_respond;
    logic [DATA_W-1:0] sv_data;
    logic [DATA_W-1:0] dm_data;
    logic [IDX_W-1:0]  sv_target;
    logic              sv_target_valid;
    logic              ho_fail;

    modport slave (
        input  start, ho_in, ack_in, dm_sq, dm_target_valid, dm_target, sv_data,
        output ho_out, ack_out, dm_request, dm_respond, dm_data, sv_target, sv_target_valid, ho_fail
    );
    modport master (
        output start, ho_in, ack_in, dm_sq, dm_target_valid, dm_target, sv_data,
        input  ho_out, ack_out, dm_request, dm_respond, dm_data, sv_target, sv_target_valid, ho_fail
    );
endinterface

// File: rtl/base_station_ho.sv
// base_station_ho: per-station attach/takeover/handover controller between DM, server and peer stations.
// Every output is a flop loaded from the next-state decode, so there is no input-to-output path.
module base_station_ho #(
    parameter int BS_ID     = 0,
    parameter int NUM_BS    = 3,
    parameter int SQ_W      = 8,
    parameter int SQ_THRESH = 50,
    parameter int LOW_CNT   = 4,
    parameter int TIMEOUT   = 8,
    parameter int DATA_W    = 8,
    localparam int IDX_W    = (NUM_BS > 1) ? $clog2(NUM_BS) : 1,
    localparam int TW       = $clog2(TIMEOUT),
    localparam int CW       = $clog2(LOW_CNT + 1)
) (
    input logic              clk,
    input logic              reset_n,
    base_station_ho_if.slave bus
);
    typedef enum logic [2:0] {IDLE, TARGET, SOURCE, CHECK_SQ, HANDOFF, NOTIFY_SV} state_t;

    localparam logic [NUM_BS-1:0] SELF_M = NUM_BS'(1) << BS_ID;
    localparam logic [IDX_W:0]    NB_L   = (IDX_W + 1)'(NUM_BS);

    state_t            state_q, state_d;
    logic [CW-1:0]     low_q, low_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]  tgt_q, tgt_d;
    logic              fail_d, low, tmo, tgt_ok, serve_q, serve_d;
    logic [NUM_BS-1:0] ho_out_q;
    logic              ack_q, req_q, resp_q, svtv_q, fail_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  svt_q;

    assign low     = bus.dm_sq < SQ_W'(SQ_THRESH);
    assign tmo     = timer_q == TW'(TIMEOUT - 1);
    assign tgt_ok  = bus.dm_target != IDX_W'(BS_ID) && {1'b0, bus.dm_target} < NB_L;
    assign serve_q = state_q == SOURCE || state_q == CHECK_SQ || state_q == HANDOFF;
    assign serve_d = state_d == SOURCE || state_d == CHECK_SQ || state_d == HANDOFF;

    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        timer_d = '0;
        tgt_d   = tgt_q;
        fail_d  = 1'b0;
        case (state_q)
            IDLE: begin
                low_d   = '0;
                state_d = |(bus.ho_in & ~SELF_M) ? TARGET : bus.start ? SOURCE : IDLE;
            end
            TARGET: state_d = SOURCE;
            SOURCE: begin
                low_d   = low ? low_q + CW'(1) : '0;
                state_d = (low && low_q == CW'(LOW_CNT - 1)) ? CHECK_SQ : SOURCE;
            end
            CHECK_SQ: begin
                timer_d = timer_q + TW'(1);
                if (bus.dm_target_valid && tgt_ok) begin
                    tgt_d   = bus.dm_target;
                    timer_d = '0;
                    state_d = HANDOFF;
                end else if (bus.dm_target_valid || tmo) begin
                    timer_d = '0;
                    low_d   = '0;
                    fail_d  = !bus.dm_target_valid;
                    state_d = SOURCE;
                end
            end
            HANDOFF: begin
                timer_d = timer_q + TW'(1);
                // the ack wins over a timeout in the same cycle
                if (bus.ack_in[tgt_q]) begin
                    timer_d = '0;
                    state_d = NOTIFY_SV;
                end else if (tmo) begin
                    timer_d = '0;
                    low_d   = '0;
                    fail_d  = 1'b1;
                    state_d = SOURCE;
                end
            end
            NOTIFY_SV: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            low_q    <= '0;
            timer_q  <= '0;
            tgt_q    <= '0;
            ho_out_q <= '0;
            ack_q    <= 1'b0;
            req_q    <= 1'b0;
            resp_q   <= 1'b0;
            data_q   <= '0;
            svt_q    <= '0;
            svtv_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            low_q    <= low_d;
            timer_q  <= timer_d;
            tgt_q    <= tgt_d;
            ho_out_q <= state_d == HANDOFF ? NUM_BS'(1) << tgt_d : '0;
            ack_q    <= state_d == TARGET;
            req_q    <= state_d == CHECK_SQ;
            resp_q   <= serve_d || state_d == TARGET;
            data_q   <= (serve_q && serve_d) ? bus.sv_data : '0;
            svt_q    <= state_d == NOTIFY_SV ? tgt_d : '0;
            svtv_q   <= state_d == NOTIFY_SV;
            fail_q   <= fail_d;
        end
    end

    assign bus.ho_out          = ho_out_q;
    assign bus.ack_out         = ack_q;
    assign bus.dm_request      = req_q;
    assign bus.dm_respond      = resp_q;
    assign bus.dm_data         = data_q;
    assign bus.sv_target       = svt_q;
    assign bus.sv_target_valid = svtv_q;
    assign bus.ho_fail         = fail_q;
endmodule

// File: tb/tb_base_station_ho.sv
// tb_base_station_ho: directed scenarios with an event scoreboard and cycle-stamped output snapshots.
module tb_base_station_ho;
    typedef struct {int kind; int val; int cyc;} ev_t;
    typedef struct {int cyc; logic [17:0] v; int id;} st_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    base_station_ho_if #(.NUM_BS(3), .SQ_W(8), .DATA_W(8)) bus ();
    base_station_ho #(
        .BS_ID(0), .NUM_BS(3), .SQ_W(8), .SQ_THRESH(50), .LOW_CNT(4), .TIMEOUT(8), .DATA_W(8)
    ) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    ev_t  ev_q[$];
    st_t  st_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done = 1'b0;
    logic reported = 1'b0;
    logic prev_req = 1'b0;
    logic [2:0] prev_ho = '0;
    logic [17:0] outs;

    // event kinds: 0 ack_out, 1 dm_request rise, 2 ho_out rise, 3 sv_target_valid, 4 ho_fail
    always @(posedge clk) cyc <= cyc + 1;

    assign outs = {bus.ho_out, bus.ack_out, bus.dm_request, bus.dm_respond, bus.dm_data,
                   bus.sv_target, bus.sv_target_valid, bus.ho_fail};

    function automatic logic [17:0] ov(input logic [2:0] ho, input logic ack, input logic req,
                                       input logic resp, input logic [7:0] d, input logic [1:0] t,
                                       input logic tv, input logic f);
        return {ho, ack, req, resp, d, t, tv, f};
    endfunction

    task automatic ev(input int k, input int v, input int lat);
        ev_t e;
        e.kind = k; e.val = v; e.cyc = cyc + lat;
        ev_q.push_back(e);
    endtask

    task automatic st(input int lat, input logic [17:0] v, input int id);
        st_t s;
        s.cyc = cyc + lat; s.v = v; s.id = id;
        st_q.push_back(s);
    endtask

    task automatic got(input int k, input int v);
        ev_t e;
        n_cmp++;
        if (ev_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: unexpected kind=%0d val=%0d at cyc %0d", k, v, cyc);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != k || e.val != v || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got kind=%0d val=%0d cyc=%0d, expected kind=%0d val=%0d cyc=%0d",
                         k, v, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        st_t s;
        if (bus.ack_out) got(0, 0);
        if (bus.dm_request && !prev_req) got(1, 0);
        if (bus.ho_out != 3'b000 && prev_ho == 3'b000) got(2, int'(bus.ho_out));
        if (bus.sv_target_valid) got(3, int'(bus.sv_target));
        if (bus.ho_fail) got(4, 0);
        prev_req <= bus.dm_request;
        prev_ho  <= bus.ho_out;
        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            s = st_q.pop_front();
            n_cmp++;
            if (s.cyc != cyc || outs !== s.v) begin
                n_bad++;
                $display("FAIL snap%0d: outputs %h at cyc %0d, expected %h at cyc %0d", s.id, outs, cyc, s.v, s.cyc);
            end
        end
        if (done && !reported) begin
            reported <= 1'b1;
            foreach (ev_q[i]) begin
                n_cmp++;
                n_bad++;
                $display("FAIL event: missing kind=%0d val=%0d cyc=%0d", ev_q[i].kind, ev_q[i].val, ev_q[i].cyc);
            end
            foreach (st_q[i]) begin
                n_cmp++;
                n_bad++;
                $display("FAIL snap%0d: never checked, expected %h", st_q[i].id, st_q[i].v);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_low();
        bus.dm_sq = 8'd40;
        ev(1, 0, 4);
        tick(4);
        bus.dm_sq = 8'd80;
    endtask

    initial begin
        int seq[8] = '{40, 40, 40, 60, 40, 40, 40, 40};
        bus.start = 0; bus.ho_in = '0; bus.ack_in = '0; bus.dm_sq = 8'd80;
        bus.dm_target_valid = 0; bus.dm_target = '0; bus.sv_data = '0;
        tick(3);
        st(1, 18'h0, 1);
        tick();
        reset_n = 1'b1;
        st(1, 18'h0, 2);
        tick();
        // attach
        bus.sv_data = 8'h5A; bus.start = 1;
        st(1, ov(0, 0, 0, 1, 8'h00, 0, 0, 0), 3);
        st(2, ov(0, 0, 0, 1, 8'h5A, 0, 0, 0), 4);
        tick();
        bus.start = 0;
        tick();
        bus.sv_data = 8'h33;
        st(1, ov(0, 0, 0, 1, 8'h33, 0, 0, 0), 5);
        tick();
        // full handover to station 2
        st(3, ov(0, 0, 0, 1, 8'h33, 0, 0, 0), 6);
        go_low();
        bus.dm_target_valid = 1; bus.dm_target = 2'd2;
        ev(2, 4, 1);
        st(1, ov(3'b100, 0, 0, 1, 8'h33, 0, 0, 0), 7);
        tick();
        bus.dm_target_valid = 0; bus.ack_in = 3'b100;
        ev(3, 2, 1);
        st(1, ov(0, 0, 0, 0, 8'h00, 2'd2, 1, 0), 8);
        st(2, 18'h0, 9);
        tick();
        bus.ack_in = '0;
        tick();
        // takeover with a simultaneous start
        bus.ho_in = 3'b010; bus.start = 1;
        ev(0, 0, 1);
        st(1, ov(0, 1, 0, 1, 8'h00, 0, 0, 0), 10);
        st(2, ov(0, 0, 0, 1, 8'h00, 0, 0, 0), 11);
        tick();
        bus.ho_in = '0; bus.start = 0;
        tick();
        // hysteresis: the 60 breaks the run
        ev(1, 0, 8);
        st(7, ov(0, 0, 0, 1, 8'h33, 0, 0, 0), 12);
        for (int i = 0; i < 8; i++) begin
            bus.dm_sq = 8'(seq[i]);
            tick();
        end
        bus.dm_sq = 8'd80;
        // DM never replies
        ev(4, 0, 8);
        st(7, ov(0, 0, 1, 1, 8'h33, 0, 0, 0), 13);
        st(8, ov(0, 0, 0, 1, 8'h33, 0, 0, 1), 14);
        tick(8);
        // self target, then out-of-range target
        go_low();
        bus.dm_target_valid = 1; bus.dm_target = 2'd0;
        st(1, ov(0, 0, 0, 1, 8'h33, 0, 0, 0), 15);
        tick();
        bus.dm_target_valid = 0;
        go_low();
        bus.dm_target_valid = 1; bus.dm_target = 2'd3;
        st(1, ov(0, 0, 0, 1, 8'h33, 0, 0, 0), 16);
        tick();
        bus.dm_target_valid = 0;
        // handover to station 1, wrong-bit acks, real ack in the timeout cycle
        go_low();
        bus.dm_target_valid = 1; bus.dm_target = 2'd1;
        ev(2, 2, 1);
        tick();
        bus.dm_target_valid = 0; bus.ack_in = 3'b100;
        st(7, ov(3'b010, 0, 0, 1, 8'h33, 0, 0, 0), 17);
        tick(7);
        bus.ack_in = 3'b010;
        ev(3, 1, 1);
        st(1, ov(0, 0, 0, 0, 8'h00, 2'd1, 1, 0), 18);
        tick();
        bus.ack_in = '0;
        tick();
        // reset in the middle of HANDOFF
        bus.start = 1;
        tick();
        bus.start = 0;
        go_low();
        bus.dm_target_valid = 1; bus.dm_target = 2'd2;
        ev(2, 4, 1);
        tick();
        bus.dm_target_valid = 0;
        tick();
        @(posedge clk);
        #1 reset_n = 1'b0;
        st(0, 18'h0, 19);
        tick(2);
        reset_n = 1'b1;
        st(1, 18'h0, 20);
        tick(3);
        st(1, 18'h0, 21);
        tick(2);
        done = 1'b1;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/base_station_ho.md
# base_station_ho

Parametrised base-station handover controller, generalising the fixed three-station base station to NUM_BS stations. It can attach a mobile through a start request or take it over from a peer station, and it forwards server data while serving. When signal quality stays low for a programmable number of cycles, it asks the device manager (DM) for a better station and hands off to it with an acknowledge handshake and a timeout. One instance is placed per station between the DM, the server (SV) and the peer stations.

## Interface
Parameters:
- BS_ID, 0: index of this station, 0..NUM_BS-1
- NUM_BS, 3: number of stations, 2..8; IDX_W = max(1, $clog2(NUM_BS))
- SQ_W, 8: signal-quality width, unsigned
- SQ_THRESH, 50: quality strictly below this counts as low
- LOW_CNT, 4: consecutive low samples that trigger a handover check, ≥1
- TIMEOUT, 8: cycles allowed for a DM reply or a peer ack, ≥2
- DATA_W, 8: data path width

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  initial attach request, sampled in IDLE
- ho_in  in  NUM_BS  bit j: station j names this station as target; bit BS_ID ignored
- ack_in  in  NUM_BS  bit j: station j acknowledges takeover
- ho_out  out  NUM_BS  one-hot handover request to target station
- ack_out  out  1  one-cycle takeover acknowledge to the source
- dm_sq  in  SQ_W  current quality of this link
- dm_target_valid  in  1  DM reply strobe
- dm_target  in  IDX_W  DM-proposed station
- dm_request  out  1  asking DM for a better station
- dm_respond  out  1  this station is serving the mobile
- sv_data  in  DATA_W  server payload
- dm_data  out  DATA_W  payload to mobile
- sv_target  out  IDX_W  new serving station, reported to server
- sv_target_valid  out  1  one-cycle strobe for sv_target
- ho_fail  out  1  one-cycle strobe when a handover is abandoned

## Operation
States: IDLE, TARGET, SOURCE, CHECK_SQ, HANDOFF, NOTIFY_SV.
- **IDLE**
  - Any ho_in[j] with j≠BS_ID goes to TARGET; this has priority over start.
  - Otherwise start goes to SOURCE; otherwise stay in IDLE.
- **TARGET**
  - Lasts one cycle: ack_out=1, then go to SOURCE.
- **SOURCE**
  - dm_respond=1; dm_data takes sv_data every cycle.
  - low_cnt increments while dm_sq<SQ_THRESH and clears otherwise.
  - When the LOW_CNT-th consecutive low sample is seen, go to CHECK_SQ with timer=0.
- **CHECK_SQ**
  - dm_request=1 and dm_respond=1; the timer increments each cycle.
  - dm_target_valid with dm_target≠BS_ID and dm_target<NUM_BS: latch tgt, go to HANDOFF with timer=0.
  - dm_target_valid with a self or out-of-range target: return to SOURCE with low_cnt=0, no ho_fail.
  - No reply when timer reaches TIMEOUT-1: ho_fail pulse, return to SOURCE with low_cnt=0.
- **HANDOFF**
  - ho_out[tgt]=1 and dm_respond=1; the timer increments each cycle.
  - ack_in[tgt] goes to NOTIFY_SV; ack_in on other bits is ignored.
  - Timeout as in CHECK_SQ: ho_fail pulse, return to SOURCE.
- **NOTIFY_SV**
  - sv_target=tgt, sv_target_valid=1 for one cycle, dm_respond=0, then go to IDLE.
- Rules common to all states:
  - ho_in and start are ignored outside IDLE.
  - A reply or ack in the same cycle as the timeout wins; ho_fail is not pulsed.
  - dm_data is 0 in IDLE, TARGET and NOTIFY_SV.
  - Illegal state encodings return to IDLE.

## Timing
- All outputs are registered: they reflect the state entered at the previous edge, with no combinational input-to-output path.
- Reset (any time, including mid-handover) takes effect immediately:
  - state=IDLE, low_cnt=0, timer=0, tgt=0;
  - ho_out=0, ack_out=0, dm_request=0, dm_respond=0, dm_data=0, sv_target=0, sv_target_valid=0, ho_fail=0.
- Latencies:
  - start sampled at edge N gives dm_respond=1 from N+1.
  - ho_in at N gives ack_out=1 in N+1 and dm_respond=1 from N+1.
  - dm_data equals sv_data delayed by one cycle.
  - The LOW_CNT-th low sample at edge N gives dm_request=1 from N+1.
  - DM reply at N gives ho_out from N+1.
  - ack_in at N gives sv_target_valid in N+1 and dm_respond=0 in N+1; IDLE is reached at N+2.
  - Timeout: CHECK_SQ/HANDOFF lasts at most TIMEOUT cycles; ho_fail is high in the first SOURCE cycle after.
- Counters:
  - low_cnt saturates at LOW_CNT.
  - The timer is $clog2(TIMEOUT) bits and never wraps.

## Test plan
All scenarios use BS_ID=0, NUM_BS=3, LOW_CNT=4, TIMEOUT=8.
- Attach: start=1 one cycle, sv_data=0x5A → dm_respond=1 next cycle, dm_data=0x5A one cycle later, no request.
- Takeover: in IDLE, ho_in=3'b010 → ack_out pulses one cycle, dm_respond=1; simultaneous start does not change the behaviour.
- Full handover:
  - dm_sq=40 for 4 cycles → dm_request=1.
  - dm_target=2 with valid → ho_out=3'b100.
  - ack_in=3'b100 → sv_target=2 with one sv_target_valid pulse, then IDLE with dm_respond=0.
- Hysteresis: dm_sq=40,40,40,60,40,40,40 → no dm_request; a 4th consecutive 40 → dm_request.
- Timeouts: no DM reply for 8 cycles → ho_fail pulse, SOURCE; dm_target=0 (self) → SOURCE without ho_fail; ack_in arriving in the timeout cycle → NOTIFY_SV, no ho_fail.
- Reset mid-HANDOFF: reset_n=0 → all outputs 0 immediately; after release, stays IDLE until start or ho_in.
